// File: rtl/id_operand_stage_if.sv
// ID/EX slot bundle: the operand stage drives the registered slot, EX returns ready.
interface id_operand_stage_if #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned REG_ADDR_W = 5
);
    logic                  out_valid;
    logic                  out_ready;
    logic [XLEN-1:0]       reg1_o;
    logic [XLEN-1:0]       reg2_o;
    logic [XLEN-1:0]       pc_o;
    logic [REG_ADDR_W-1:0] wd_o;
    logic                  wreg_o;

    modport master (
        output out_valid, reg1_o, reg2_o, pc_o, wd_o, wreg_o,
        input  out_ready
    );

    modport slave (
        input  out_valid, reg1_o, reg2_o, pc_o, wd_o, wreg_o,
        output out_ready
    );
endinterface

// File: rtl/id_operand_stage.sv
// Decode-stage operand fetch: regfile read, prioritised forwarding with load-use
// stall, and a registered ID/EX slot with valid/ready handshake.
module id_operand_stage #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned NUM_FWD    = 2,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [XLEN-1:0]               pc_i,
    input  logic                          reg1_read_i,
    input  logic                          reg2_read_i,
    input  logic [REG_ADDR_W-1:0]         reg1_addr_i,
    input  logic [REG_ADDR_W-1:0]         reg2_addr_i,
    input  logic [XLEN-1:0]               imm_i,
    input  logic [REG_ADDR_W-1:0]         wd_i,
    input  logic                          wreg_i,
    output logic                          reg1_read_o,
    output logic                          reg2_read_o,
    output logic [REG_ADDR_W-1:0]         reg1_addr_o,
    output logic [REG_ADDR_W-1:0]         reg2_addr_o,
    input  logic [XLEN-1:0]               reg1_data_i,
    input  logic [XLEN-1:0]               reg2_data_i,
    input  logic [NUM_FWD-1:0]            fwd_wreg_i,
    input  logic [NUM_FWD*REG_ADDR_W-1:0] fwd_wd_i,
    input  logic [NUM_FWD*XLEN-1:0]       fwd_wdata_i,
    input  logic [NUM_FWD-1:0]            fwd_pending_i,
    input  logic                          flush_i,
    id_operand_stage_if.master            ex,
    output logic                          stallreq,
    output logic [CNT_W-1:0]              stall_cnt_o
);

    logic [XLEN-1:0]       op1, op2;
    logic                  hz1, hz2, hazard, slot_free;
    logic                  valid_q, valid_d;
    logic [XLEN-1:0]       reg1_q, reg1_d, reg2_q, reg2_d, pc_q, pc_d;
    logic [REG_ADDR_W-1:0] wd_q, wd_d;
    logic                  wreg_q, wreg_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    // Returns {hazard, value}; the first matching channel wins and decides the hazard.
    function automatic logic [XLEN:0] resolve(
        input logic                          rd,
        input logic [REG_ADDR_W-1:0]         addr,
        input logic [XLEN-1:0]               rdata,
        input logic [XLEN-1:0]               imm,
        input logic [NUM_FWD-1:0]            we,
        input logic [NUM_FWD*REG_ADDR_W-1:0] wd,
        input logic [NUM_FWD*XLEN-1:0]       wdata,
        input logic [NUM_FWD-1:0]            pend
    );
        logic            found;
        logic [XLEN-1:0] val;
        logic            hz;
        found = 1'b0;
        val   = rdata;
        hz    = 1'b0;
        if (!rd) begin
            val = imm;
        end else if (addr == '0) begin
            val = '0;
        end else begin
            for (int unsigned k = 0; k < NUM_FWD; k++) begin
                if (!found && we[k] && wd[k*REG_ADDR_W +: REG_ADDR_W] == addr) begin
                    found = 1'b1;
                    val   = wdata[k*XLEN +: XLEN];
                    hz    = pend[k];
                end
            end
        end
        return {hz, val};
    endfunction

    assign reg1_read_o = reg1_read_i;
    assign reg2_read_o = reg2_read_i;
    assign reg1_addr_o = reg1_addr_i;
    assign reg2_addr_o = reg2_addr_i;

    always_comb begin
        {hz1, op1} = resolve(reg1_read_i, reg1_addr_i, reg1_data_i, imm_i,
                             fwd_wreg_i, fwd_wd_i, fwd_wdata_i, fwd_pending_i);
        {hz2, op2} = resolve(reg2_read_i, reg2_addr_i, reg2_data_i, imm_i,
                             fwd_wreg_i, fwd_wd_i, fwd_wdata_i, fwd_pending_i);
    end

    assign hazard    = in_valid & (hz1 | hz2);
    assign slot_free = !valid_q | ex.out_ready;
    assign in_ready  = !flush_i & !hazard & slot_free;
    assign stallreq  = in_valid & !in_ready & !flush_i;

    always_comb begin
        valid_d = valid_q;
        reg1_d  = reg1_q;
        reg2_d  = reg2_q;
        pc_d    = pc_q;
        wd_d    = wd_q;
        wreg_d  = wreg_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (in_valid && in_ready) begin
            valid_d = 1'b1;
            reg1_d  = op1;
            reg2_d  = op2;
            pc_d    = pc_i;
            wd_d    = wd_i;
            wreg_d  = wreg_i;
        end else if (ex.out_ready) begin
            valid_d = 1'b0;
        end
        cnt_d = (stallreq && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            reg1_q  <= '0;
            reg2_q  <= '0;
            pc_q    <= '0;
            wd_q    <= '0;
            wreg_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            reg1_q  <= reg1_d;
            reg2_q  <= reg2_d;
            pc_q    <= pc_d;
            wd_q    <= wd_d;
            wreg_q  <= wreg_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ex.out_valid = valid_q;
    assign ex.reg1_o    = reg1_q;
    assign ex.reg2_o    = reg2_q;
    assign ex.pc_o      = pc_q;
    assign ex.wd_o      = wd_q;
    assign ex.wreg_o    = wreg_q;
    assign stall_cnt_o  = cnt_q;

endmodule

// File: tb/tb_id_operand_stage.sv
// Directed vector bench for id_operand_stage, with a CNT_W=4 twin for saturation.
module tb_id_operand_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, flush_i, ordy;
    logic [31:0] pc_i, imm_i;
    logic        r1rd, r2rd, wreg_i;
    logic [4:0]  r1a, r2a, wd_i;
    logic [1:0]  fwe, fpend;
    logic [4:0]  fwd0, fwd1;
    logic [31:0] fd0, fd1;

    logic        in_ready, stallreq, s_in_ready, s_stallreq;
    logic        r1rd_o, r2rd_o, s_r1rd_o, s_r2rd_o;
    logic [4:0]  r1a_o, r2a_o, s_r1a_o, s_r2a_o;
    logic [31:0] r1data, r2data, s_r1data, s_r2data;
    logic [15:0] cnt;
    logic [3:0]  s_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_operand_stage_if #(.XLEN(32), .REG_ADDR_W(5)) m_if ();
    id_operand_stage_if #(.XLEN(32), .REG_ADDR_W(5)) s_if ();
    assign m_if.out_ready = ordy;
    assign s_if.out_ready = ordy;

    // Regfile stand-in: read data encodes the requested index.
    assign r1data   = 32'hA000_0000 | {27'b0, r1a_o};
    assign r2data   = 32'hB000_0000 | {27'b0, r2a_o};
    assign s_r1data = 32'hA000_0000 | {27'b0, s_r1a_o};
    assign s_r2data = 32'hB000_0000 | {27'b0, s_r2a_o};

    id_operand_stage #(.XLEN(32), .REG_ADDR_W(5), .NUM_FWD(2), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .pc_i(pc_i),
        .reg1_read_i(r1rd), .reg2_read_i(r2rd), .reg1_addr_i(r1a), .reg2_addr_i(r2a),
        .imm_i(imm_i), .wd_i(wd_i), .wreg_i(wreg_i),
        .reg1_read_o(r1rd_o), .reg2_read_o(r2rd_o), .reg1_addr_o(r1a_o), .reg2_addr_o(r2a_o),
        .reg1_data_i(r1data), .reg2_data_i(r2data),
        .fwd_wreg_i(fwe), .fwd_wd_i({fwd1, fwd0}), .fwd_wdata_i({fd1, fd0}),
        .fwd_pending_i(fpend), .flush_i(flush_i), .ex(m_if),
        .stallreq(stallreq), .stall_cnt_o(cnt)
    );

    id_operand_stage #(.XLEN(32), .REG_ADDR_W(5), .NUM_FWD(2), .CNT_W(4)) u_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready), .pc_i(pc_i),
        .reg1_read_i(r1rd), .reg2_read_i(r2rd), .reg1_addr_i(r1a), .reg2_addr_i(r2a),
        .imm_i(imm_i), .wd_i(wd_i), .wreg_i(wreg_i),
        .reg1_read_o(s_r1rd_o), .reg2_read_o(s_r2rd_o), .reg1_addr_o(s_r1a_o), .reg2_addr_o(s_r2a_o),
        .reg1_data_i(s_r1data), .reg2_data_i(s_r2data),
        .fwd_wreg_i(fwe), .fwd_wd_i({fwd1, fwd0}), .fwd_wdata_i({fd1, fd0}),
        .fwd_pending_i(fpend), .flush_i(flush_i), .ex(s_if),
        .stallreq(s_stallreq), .stall_cnt_o(s_cnt)
    );

    typedef struct {
        logic        iv;
        logic        r1rd;
        logic [4:0]  r1a;
        logic        r2rd;
        logic [4:0]  r2a;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [4:0]  wd;
        logic        wreg;
        logic [1:0]  fwe;
        logic [4:0]  fwd0;
        logic [4:0]  fwd1;
        logic [31:0] fd0;
        logic [31:0] fd1;
        logic [1:0]  fpend;
        logic        flush;
        logic        ordy;
        logic        e_rdy;
        logic        e_stall;
        logic        e_ov;
        logic [31:0] e_r1;
        logic [31:0] e_r2;
        logic [31:0] e_pc;
        logic [4:0]  e_wd;
        logic        e_wreg;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input logic iv, input logic rd1, input logic [4:0] a1,
                          input logic rd2, input logic [4:0] a2, input logic [31:0] imm,
                          input logic [31:0] pc, input logic [1:0] we, input logic [4:0] w0,
                          input logic [31:0] d0, input logic [1:0] pd, input logic fl,
                          input logic rdy);
        in_valid = iv; r1rd = rd1; r1a = a1; r2rd = rd2; r2a = a2; imm_i = imm;
        pc_i = pc; wd_i = 5'd9; wreg_i = 1'b1; fwe = we; fwd0 = w0; fwd1 = 5'd0;
        fd0 = d0; fd1 = 32'h0; fpend = pd; flush_i = fl; ordy = rdy;
    endtask

    initial begin
        set_in(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 32'h0, 2'b00, 5'd0, 32'h0, 2'b00, 1'b0, 1'b1);
        rst = 1'b1;
        #1;
        chk("reset_ov",   32'(m_if.out_valid), 32'h0);
        chk("reset_r1",   m_if.reg1_o, 32'h0);
        chk("reset_r2",   m_if.reg2_o, 32'h0);
        chk("reset_pc",   m_if.pc_o, 32'h0);
        chk("reset_wd",   32'(m_if.wd_o), 32'h0);
        chk("reset_wreg", 32'(m_if.wreg_o), 32'h0);
        chk("reset_cnt",  32'(cnt), 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        //          iv   r1rd r1a    r2rd r2a     imm            pc          wd    wreg fwe    fwd0   fwd1   fd0            fd1          fpend  fl   ordy  rdy  stl  ov   r1             r2             pc          wd    wreg
        vecs[0] = '{1'b1,1'b1,5'd5,  1'b1,5'd7,  32'h0,        32'h100,    5'd1, 1'b1,2'b11,5'd5, 5'd5, 32'h11,        32'h22,      2'b00,1'b0,1'b1, 1'b1,1'b0,1'b1,32'h11,        32'hB000_0007, 32'h100,    5'd1, 1'b1};
        vecs[1] = '{1'b1,1'b1,5'd5,  1'b1,5'd9,  32'h0,        32'h104,    5'd2, 1'b0,2'b10,5'd0, 5'd5, 32'h0,         32'h22,      2'b00,1'b0,1'b1, 1'b1,1'b0,1'b1,32'h22,        32'hB000_0009, 32'h104,    5'd2, 1'b0};
        vecs[2] = '{1'b1,1'b1,5'd0,  1'b0,5'd0,  32'hFFFF_F800,32'h108,    5'd3, 1'b1,2'b01,5'd0, 5'd0, 32'hFF,        32'h0,       2'b01,1'b0,1'b1, 1'b1,1'b0,1'b1,32'h0,         32'hFFFF_F800, 32'h108,    5'd3, 1'b1};
        vecs[3] = '{1'b1,1'b1,5'd4,  1'b0,5'd0,  32'h7,        32'h10C,    5'd4, 1'b1,2'b11,5'd4, 5'd4, 32'h44,        32'h55,      2'b10,1'b0,1'b1, 1'b1,1'b0,1'b1,32'h44,        32'h7,         32'h10C,    5'd4, 1'b1};
        vecs[4] = '{1'b1,1'b0,5'd0,  1'b1,5'd3,  32'h1,        32'h110,    5'd5, 1'b1,2'b01,5'd3, 5'd0, 32'h0,         32'h0,       2'b01,1'b0,1'b1, 1'b0,1'b1,1'b0,32'h44,        32'h7,         32'h10C,    5'd4, 1'b1};
        vecs[5] = '{1'b1,1'b0,5'd0,  1'b1,5'd3,  32'h1,        32'h110,    5'd5, 1'b1,2'b10,5'd3, 5'd3, 32'h0,         32'h0,       2'b10,1'b0,1'b1, 1'b0,1'b1,1'b0,32'h44,        32'h7,         32'h10C,    5'd4, 1'b1};
        vecs[6] = '{1'b0,1'b0,5'd0,  1'b1,5'd3,  32'h1,        32'h110,    5'd5, 1'b1,2'b10,5'd3, 5'd3, 32'h0,         32'h0,       2'b10,1'b0,1'b1, 1'b1,1'b0,1'b0,32'h44,        32'h7,         32'h10C,    5'd4, 1'b1};
        vecs[7] = '{1'b1,1'b0,5'd0,  1'b1,5'd3,  32'h1,        32'h110,    5'd5, 1'b1,2'b01,5'd3, 5'd0, 32'hABCD,      32'h0,       2'b00,1'b0,1'b1, 1'b1,1'b0,1'b1,32'h1,         32'hABCD,      32'h110,    5'd5, 1'b1};
        vecs[8] = '{1'b1,1'b1,5'd6,  1'b1,5'd6,  32'h0,        32'h114,    5'd6, 1'b1,2'b00,5'd0, 5'd0, 32'h0,         32'h0,       2'b00,1'b1,1'b0, 1'b0,1'b0,1'b0,32'h1,         32'hABCD,      32'h110,    5'd5, 1'b1};
        vecs[9] = '{1'b1,1'b1,5'd5,  1'b1,5'd31, 32'h0,        32'h118,    5'd7, 1'b0,2'b00,5'd5, 5'd0, 32'h99,        32'h0,       2'b00,1'b0,1'b1, 1'b1,1'b0,1'b1,32'hA000_0005, 32'hB000_001F, 32'h118,    5'd7, 1'b0};

        for (int i = 0; i < 10; i++) begin
            in_valid = vecs[i].iv;   r1rd = vecs[i].r1rd; r1a = vecs[i].r1a;
            r2rd = vecs[i].r2rd;     r2a = vecs[i].r2a;   imm_i = vecs[i].imm;
            pc_i = vecs[i].pc;       wd_i = vecs[i].wd;   wreg_i = vecs[i].wreg;
            fwe = vecs[i].fwe;       fwd0 = vecs[i].fwd0; fwd1 = vecs[i].fwd1;
            fd0 = vecs[i].fd0;       fd1 = vecs[i].fd1;   fpend = vecs[i].fpend;
            flush_i = vecs[i].flush; ordy = vecs[i].ordy;
            #1;
            chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].e_rdy));
            chk($sformatf("v%0d_stallreq", i), 32'(stallreq), 32'(vecs[i].e_stall));
            chk($sformatf("v%0d_addr1_o", i), {26'b0, r1rd_o, r1a_o}, {26'b0, vecs[i].r1rd, vecs[i].r1a});
            chk($sformatf("v%0d_addr2_o", i), {26'b0, r2rd_o, r2a_o}, {26'b0, vecs[i].r2rd, vecs[i].r2a});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_out_valid", i), 32'(m_if.out_valid), 32'(vecs[i].e_ov));
            chk($sformatf("v%0d_reg1", i), m_if.reg1_o, vecs[i].e_r1);
            chk($sformatf("v%0d_reg2", i), m_if.reg2_o, vecs[i].e_r2);
            chk($sformatf("v%0d_pc", i), m_if.pc_o, vecs[i].e_pc);
            chk($sformatf("v%0d_wd_wreg", i), {26'b0, m_if.wreg_o, m_if.wd_o}, {26'b0, vecs[i].e_wreg, vecs[i].e_wd});
        end
        chk("table_stall_cnt", 32'(cnt), 32'd2);

        // Backpressure: drain-and-accept A, then hold B off for 3 cycles.
        set_in(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 32'hAAAA, 32'h200, 2'b00, 5'd0, 32'h0, 2'b00, 1'b0, 1'b1);
        #1 chk("bp_accept_a_ready", 32'(in_ready), 32'h1);
        @(posedge clk); #1;
        chk("bp_a_reg1", m_if.reg1_o, 32'hAAAA);
        set_in(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 32'hBBBB, 32'h204, 2'b00, 5'd0, 32'h0, 2'b00, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("bp%0d_in_ready", c), 32'(in_ready), 32'h0);
            chk($sformatf("bp%0d_stallreq", c), 32'(stallreq), 32'h1);
            @(posedge clk); #1;
            chk($sformatf("bp%0d_hold_ov", c), 32'(m_if.out_valid), 32'h1);
            chk($sformatf("bp%0d_hold_reg1", c), m_if.reg1_o, 32'hAAAA);
            chk($sformatf("bp%0d_hold_pc", c), m_if.pc_o, 32'h200);
        end
        ordy = 1'b1;
        #1 chk("bp_release_ready", 32'(in_ready), 32'h1);
        @(posedge clk); #1;
        chk("bp_b_ov", 32'(m_if.out_valid), 32'h1);
        chk("bp_b_reg2", m_if.reg2_o, 32'hBBBB);
        chk("bp_b_pc", m_if.pc_o, 32'h204);
        chk("bp_stall_cnt", 32'(cnt), 32'd5);

        // Flush with EX ready and a hazard present at the same time.
        set_in(1'b1, 1'b1, 5'd3, 1'b0, 5'd0, 32'hCCCC, 32'h208, 2'b01, 5'd3, 32'h0, 2'b01, 1'b1, 1'b1);
        #1;
        chk("flush_stallreq", 32'(stallreq), 32'h0);
        chk("flush_in_ready", 32'(in_ready), 32'h0);
        @(posedge clk); #1;
        chk("flush_ov", 32'(m_if.out_valid), 32'h0);
        chk("flush_pc_kept", m_if.pc_o, 32'h204);
        chk("flush_stall_cnt", 32'(cnt), 32'd5);

        // Fill the slot, stall on it, then assert reset between edges.
        set_in(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 32'hDDDD, 32'h20C, 2'b00, 5'd0, 32'h0, 2'b00, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("rstseq_fill_ov", 32'(m_if.out_valid), 32'h1);
        set_in(1'b1, 1'b1, 5'd3, 1'b0, 5'd0, 32'h0, 32'h210, 2'b01, 5'd3, 32'h0, 2'b01, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("rstseq_cnt_before", 32'(cnt), 32'd6);
        #3 rst = 1'b1;
        #1;
        chk("async_rst_ov", 32'(m_if.out_valid), 32'h0);
        chk("async_rst_cnt", 32'(cnt), 32'h0);
        chk("async_rst_reg1", m_if.reg1_o, 32'h0);
        #2 rst = 1'b0;

        // 20 hazard cycles: full-width counter reaches 20, 4-bit twin pins at 15.
        repeat (20) @(posedge clk);
        #1;
        chk("sat_stallreq", 32'(s_stallreq), 32'h1);
        chk("cnt16_after20", 32'(cnt), 32'd20);
        chk("cnt4_saturated", 32'(s_cnt), 32'd15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
